// File: rtl/axis_pack_upsizer_if.sv
// Narrow-in / wide-out AXI-Stream bundle for the pack upsizer.
// The slave modport is the upsizer's view; master is the surrounding environment.
interface axis_pack_upsizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 4
);
    logic [DATA_WIDTH-1:0]       s_payload;
    logic                        s_last;
    logic                        s_valid;
    logic                        s_ready;
    logic [DATA_WIDTH*RATIO-1:0] m_payload;
    logic [RATIO-1:0]            m_keep;
    logic                        m_last;
    logic                        m_valid;
    logic                        m_ready;

    modport slave (
        input  s_payload, s_last, s_valid, m_ready,
        output s_ready, m_payload, m_keep, m_last, m_valid
    );

    modport master (
        output s_payload, s_last, s_valid, m_ready,
        input  s_ready, m_payload, m_keep, m_last, m_valid
    );
endinterface

// File: rtl/axis_pack_upsizer.sv
// AXI-Stream upsizer: packs RATIO narrow beats LSB-first into one registered wide word.
// s_last flushes a partial word early; unfilled lanes and their keep bits read as zero.
module axis_pack_upsizer #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 4
) (
    input logic                clk,
    input logic                rst,
    axis_pack_upsizer_if.slave bus
);
    localparam int                   CNT_WIDTH  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int                   WIDE_WIDTH = DATA_WIDTH * RATIO;
    localparam logic [CNT_WIDTH-1:0] LAST_LANE  = CNT_WIDTH'(RATIO - 1);

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDE_WIDTH-1:0] acc_q, acc_d;
    logic [RATIO-1:0]      acc_keep_q, acc_keep_d;
    logic [WIDE_WIDTH-1:0] m_payload_q, m_payload_d;
    logic [RATIO-1:0]      m_keep_q, m_keep_d;
    logic                  m_last_q, m_last_d;
    logic                  m_valid_q, m_valid_d;

    logic                  s_ready;
    logic                  accept;
    logic                  complete;
    logic [WIDE_WIDTH-1:0] acc_merged;
    logic [RATIO-1:0]      keep_merged;

    assign s_ready  = !m_valid_q || bus.m_ready;
    assign accept   = bus.s_valid && s_ready;
    assign complete = accept && ((cnt_q == LAST_LANE) || bus.s_last);

    // Accumulator with the current beat dropped into lane cnt_q.
    always_comb begin
        acc_merged  = acc_q;
        keep_merged = acc_keep_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (cnt_q == CNT_WIDTH'(i)) begin
                acc_merged[i*DATA_WIDTH +: DATA_WIDTH] = bus.s_payload;
                keep_merged[i]                         = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        acc_keep_d  = acc_keep_q;
        m_payload_d = m_payload_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;

        if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end

        // The accumulator data is cleared too, so stale lanes never leak into a short word.
        if (complete) begin
            m_payload_d = acc_merged;
            m_keep_d    = keep_merged;
            m_last_d    = bus.s_last;
            m_valid_d   = 1'b1;
            cnt_d       = '0;
            acc_d       = '0;
            acc_keep_d  = '0;
        end else if (accept) begin
            cnt_d      = cnt_q + CNT_WIDTH'(1);
            acc_d      = acc_merged;
            acc_keep_d = keep_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            acc_keep_q  <= '0;
            m_payload_q <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            acc_keep_q  <= acc_keep_d;
            m_payload_q <= m_payload_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_payload = m_payload_q;
    assign bus.m_keep    = m_keep_q;
    assign bus.m_last    = m_last_q;
    assign bus.m_valid   = m_valid_q;
endmodule

// File: tb/tb_axis_pack_upsizer.sv
// Bench for axis_pack_upsizer (8-bit beats, RATIO 4): directed cases plus random packets
// scored against a packet-chunking reference model.
module tb_axis_pack_upsizer;
    localparam int DW = 8;
    localparam int R  = 4;

    typedef struct {
        logic [DW*R-1:0] payload;
        logic [R-1:0]    keep;
        logic            last;
    } word_t;

    logic        clk;
    logic        rst;
    logic [1:0]  ready_mode;  // 0: hold low, 1: hold high, 2: random
    logic        rnd_ready;
    int unsigned checks = 0;
    int unsigned errors = 0;

    word_t           exp_q[$];
    logic [DW-1:0]   pkt[$];
    word_t           mon_w;
    logic            held;
    logic [DW*R-1:0] held_payload;
    logic [R-1:0]    held_keep;
    logic            held_last;
    int unsigned     waited;
    int unsigned     stalls;

    axis_pack_upsizer_if #(.DATA_WIDTH(DW), .RATIO(R)) bus ();

    axis_pack_upsizer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.m_ready = (ready_mode == 2'd2) ? rnd_ready : ready_mode[0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 rnd_ready = 1'($urandom_range(1));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW*R-1:0] p, input logic [R-1:0] k, input logic l);
        word_t w;
        w.payload = p;
        w.keep    = k;
        w.last    = l;
        exp_q.push_back(w);
    endtask

    // Reference: split the packet into chunks of R beats, last chunk may be short.
    task automatic model_packet();
        int unsigned n = pkt.size();
        for (int unsigned base = 0; base < n; base += R) begin
            word_t       w;
            int unsigned take;
            take      = (n - base < R) ? (n - base) : R;
            w.payload = '0;
            for (int unsigned k = 0; k < take; k++) begin
                w.payload[k*DW +: DW] = pkt[base+k];
            end
            w.keep = R'((1 << take) - 1);
            w.last = (base + take == n);
            exp_q.push_back(w);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l, output int unsigned wcount);
        bus.s_payload = d;
        bus.s_last    = l;
        bus.s_valid   = 1'b1;
        wcount        = 0;
        @(negedge clk);
        while (!bus.s_ready && wcount < 500) begin
            wcount++;
            @(negedge clk);
        end
        chk("accept_in_time", bus.s_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int unsigned guard = 0;
        bus.s_valid = 1'b0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Output monitor: handshake scoreboard, hold stability, ready rule, keep never zero.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            chk("s_ready_rule", bus.s_ready, !bus.m_valid || bus.m_ready);
            if (bus.m_valid) chk("keep_nonzero", bus.m_keep != '0, 1);
            if (held) begin
                chk("hold_valid", bus.m_valid, 1);
                chk("hold_word", {bus.m_payload, bus.m_keep, bus.m_last},
                    {held_payload, held_keep, held_last});
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_w = exp_q.pop_front();
                    chk("word", {bus.m_payload, bus.m_keep, bus.m_last},
                        {mon_w.payload, mon_w.keep, mon_w.last});
                end
            end
            held         = bus.m_valid && !bus.m_ready;
            held_payload = bus.m_payload;
            held_keep    = bus.m_keep;
            held_last    = bus.m_last;
        end
    end

    initial begin
        rst           = 1'b1;
        ready_mode    = 2'd1;
        held          = 1'b0;
        bus.s_payload = '0;
        bus.s_last    = 1'b0;
        bus.s_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_valid", bus.m_valid, 0);
        chk("reset_m_keep", bus.m_keep, 0);
        chk("reset_m_payload", bus.m_payload, 0);
        chk("reset_m_last", bus.m_last, 0);
        chk("reset_s_ready", bus.s_ready, 1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Full word with last on lane 3; visible one cycle after the 4th beat.
        push_word(32'h44332211, 4'b1111, 1'b1);
        send_beat(8'h11, 1'b0, waited);
        send_beat(8'h22, 1'b0, waited);
        send_beat(8'h33, 1'b0, waited);
        chk("no_early_valid", bus.m_valid, 0);
        send_beat(8'h44, 1'b1, waited);
        chk("latency_valid", bus.m_valid, 1);
        chk("first_word", {bus.m_payload, bus.m_keep, bus.m_last}, {32'h44332211, 4'b1111, 1'b1});
        idle();
        drain();

        // Short packets flush early.
        push_word(32'h0000A2A1, 4'b0011, 1'b1);
        push_word(32'h000000B1, 4'b0001, 1'b1);
        send_beat(8'hA1, 1'b0, waited);
        send_beat(8'hA2, 1'b1, waited);
        chk("two_beat_word", {bus.m_payload, bus.m_keep, bus.m_last}, {32'h0000A2A1, 4'b0011, 1'b1});
        send_beat(8'hB1, 1'b1, waited);
        chk("single_beat_word", {bus.m_payload, bus.m_keep, bus.m_last}, {32'h000000B1, 4'b0001, 1'b1});
        drain();

        // 10-beat packet back-to-back at full throughput.
        push_word(32'h04030201, 4'b1111, 1'b0);
        push_word(32'h08070605, 4'b1111, 1'b0);
        push_word(32'h00000A09, 4'b0011, 1'b1);
        stalls = 0;
        for (int unsigned i = 1; i <= 10; i++) begin
            send_beat(8'(i), i == 10, waited);
            stalls += waited;
        end
        chk("no_stall_10beat", stalls, 0);
        drain();

        // Backpressure hold for 20 cycles with the next beat already offered.
        push_word(32'h04030201, 4'b1111, 1'b0);
        push_word(32'h08070605, 4'b1111, 1'b1);
        ready_mode = 2'd0;
        for (int unsigned i = 1; i <= 4; i++) send_beat(8'(i), 1'b0, waited);
        bus.s_payload = 8'h05;
        bus.s_last    = 1'b0;
        bus.s_valid   = 1'b1;
        for (int unsigned c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("hold_s_ready_low", bus.s_ready, 0);
            chk("hold_first_word", {bus.m_valid, bus.m_payload, bus.m_keep, bus.m_last},
                {1'b1, 32'h04030201, 4'b1111, 1'b0});
        end
        @(posedge clk);
        #1 ready_mode = 2'd1;
        for (int unsigned i = 5; i <= 8; i++) send_beat(8'(i), i == 8, waited);
        drain();

        // Reset with two beats in the accumulator.
        send_beat(8'hC1, 1'b0, waited);
        send_beat(8'hC2, 1'b0, waited);
        bus.s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_partial_valid", {bus.m_valid, bus.m_keep, bus.m_payload, bus.m_last}, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset while a word is pending on the output: valid drops without a clock edge.
        ready_mode = 2'd0;
        send_beat(8'hD1, 1'b1, waited);
        chk("pending_valid", bus.m_valid, 1);
        bus.s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", bus.m_valid, 0);
        chk("rst_async_word", {bus.m_payload, bus.m_keep, bus.m_last}, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1 ready_mode = 2'd1;

        push_word(32'h88776655, 4'b1111, 1'b1);
        send_beat(8'h55, 1'b0, waited);
        send_beat(8'h66, 1'b0, waited);
        send_beat(8'h77, 1'b0, waited);
        send_beat(8'h88, 1'b1, waited);
        chk("post_reset_word", {bus.m_payload, bus.m_keep, bus.m_last}, {32'h88776655, 4'b1111, 1'b1});
        drain();

        // Random packets with random valid gaps and random ready.
        ready_mode = 2'd2;
        for (int unsigned p = 0; p < 1000; p++) begin
            pkt.delete();
            for (int unsigned k = 0, n = $urandom_range(10, 1); k < n; k++) begin
                pkt.push_back(8'($urandom_range(255)));
            end
            model_packet();
            for (int unsigned k = 0; k < pkt.size(); k++) begin
                if ($urandom_range(1) == 0) idle();
                send_beat(pkt[k], k == pkt.size() - 1, waited);
            end
        end
        bus.s_valid = 1'b0;
        ready_mode  = 2'd1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
